// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core, one round per clock, round keys expanded on the fly.
// Optional define AES_CT_CLEAR_EN: ct reads zero whenever valid is low.
module aes_encrypt_core #(
    parameter int NK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [32*NK-1:0] key,
    input  logic            load,
    input  logic [127:0]    pt,
    output logic [127:0]    ct,
    output logic            valid
);

    generate
        if (NK != 4) begin : g_nk_check
            $error("aes_encrypt_core: only NK=4 (AES-128) is supported");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rkey_q, rkey_d;
    logic [127:0] ct_q, ct_d;
    logic         valid_q, valid_d;

    logic [127:0] rkey_nxt, round_out;
    logic [31:0]  ks_tmp, ks_w0, ks_w1, ks_w2, ks_w3;
    logic [7:0]   sb_b [16];
    logic [7:0]   sr_b [16];
    logic [31:0]  col;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // S-box as multiplicative inverse (a^254, zero maps to zero) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        ks_w3    = rkey_q[31:0];
        ks_tmp   = {sbox(ks_w3[23:16]), sbox(ks_w3[15:8]), sbox(ks_w3[7:0]), sbox(ks_w3[31:24])}
                 ^ {rcon(round_q), 24'h0};
        ks_w0    = rkey_q[127:96] ^ ks_tmp;
        ks_w1    = rkey_q[95:64]  ^ ks_w0;
        ks_w2    = rkey_q[63:32]  ^ ks_w1;
        rkey_nxt = {ks_w0, ks_w1, ks_w2, ks_w3 ^ ks_w2};
    end

    // Byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4
    always_comb begin
        round_out = '0;
        col       = '0;
        for (int i = 0; i < 16; i++) sb_b[i] = sbox(st_q[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr_b[r+4*c] = sb_b[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            col = {sr_b[4*c], sr_b[4*c+1], sr_b[4*c+2], sr_b[4*c+3]};
            if (round_q != 4'd10) col = mix_col(col);
            round_out[127-32*c -: 32] = col ^ rkey_nxt[127-32*c -: 32];
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        st_d    = st_q;
        rkey_d  = rkey_q;
        ct_d    = ct_q;
        valid_d = valid_q;
        case (fsm_q)
            IDLE: begin
                valid_d = 1'b0;
                if (load) begin
                    st_d    = pt ^ key;
                    rkey_d  = key;
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (!load) begin
                    fsm_d   = IDLE;
                    valid_d = 1'b0;
                    round_d = 4'd0;
                end else begin
                    st_d    = round_out;
                    rkey_d  = rkey_nxt;
                    round_d = round_q + 4'd1;
                    if (round_q == 4'd10) begin
                        ct_d    = round_out;
                        valid_d = 1'b1;
                        fsm_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (!load) begin
                    fsm_d   = IDLE;
                    valid_d = 1'b0;
                    round_d = 4'd0;
                end
            end
            default: begin
                fsm_d   = IDLE;
                valid_d = 1'b0;
                round_d = 4'd0;
            end
        endcase
`ifdef AES_CT_CLEAR_EN
        if (!valid_d) ct_d = '0;
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            st_q    <= '0;
            rkey_q  <= '0;
            ct_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            st_q    <= st_d;
            rkey_q  <= rkey_d;
            ct_q    <= ct_d;
            valid_q <= valid_d;
        end
    end

    assign ct    = ct_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Self-checking bench for aes_encrypt_core: FIPS-197 vectors, aborts, restarts and random vectors
// against a byte-array AES-128 model with a generator-built S-box.
module tb_aes_encrypt_core;

    logic         clk;
    logic         rst_n;
    logic [127:0] key;
    logic         load;
    logic [127:0] pt;
    logic [127:0] ct;
    logic         valid;

    int n_tests;
    int n_fail;

    logic [7:0]   sbox_t [256];
    logic [127:0] last_res;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_encrypt_core #(.NK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key),
        .load  (load),
        .pt    (pt),
        .ct    (ct),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] gmul_m(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x, y;
        r = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return r;
    endfunction

    // Walk p over the generator 3 and q over its inverse, so sbox[p] = affine(1/p)
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tw;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {sbox_t[tw[23:16]], sbox_t[tw[15:8]], sbox_t[tw[7:0]], sbox_t[tw[31:24]]}
                   ^ {rc, 24'h0};
                rc = gmul_m(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int i = 0; i < 16; i++) t[i] = s[(i%4) + 4*(((i/4) + (i%4)) % 4)];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul_m(a0, 8'h02) ^ gmul_m(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul_m(a1, 8'h02) ^ gmul_m(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul_m(a2, 8'h02) ^ gmul_m(a3, 8'h03);
                    s[4*c+3] = gmul_m(a0, 8'h03) ^ a1 ^ a2 ^ gmul_m(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] idle_ct(input logic [127:0] held);
`ifdef AES_CT_CLEAR_EN
        return 128'h0;
`else
        return held;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise load with the given operands, then count edges after capture until valid (bounded)
    task automatic start_and_wait(input logic [127:0] k, input logic [127:0] p, output int lat);
        key  = k;
        pt   = p;
        load = 1'b1;
        tick();
        lat = 0;
        while (!valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        key   = rand128();
        pt    = rand128();
        #3;
        n_tests++;
        if (ct !== 128'h0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: ct=%h valid=%b want ct=0 valid=0", ct, valid);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            key = rand128();
            pt  = rand128();
            tick();
            n_tests++;
            if (ct !== 128'h0 || valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: ct=%h valid=%b want 0/0", i, ct, valid);
            end
        end
        last_res = 128'h0;
    endtask

    task automatic test_fips_c1();
        int lat;
        start_and_wait(C1_KEY, C1_PT, lat);
        n_tests++;
        if (lat !== 10) begin
            n_fail++;
            $display("FAIL c1_latency: got %0d want 10", lat);
        end
        n_tests++;
        if (ct !== C1_CT) begin
            n_fail++;
            $display("FAIL c1_ct: got %h want %h", ct, C1_CT);
        end
        n_tests++;
        if (model_enc(C1_KEY, C1_PT) !== C1_CT) begin
            n_fail++;
            $display("FAIL c1_model: got %h want %h", model_enc(C1_KEY, C1_PT), C1_CT);
        end
        last_res = C1_CT;
    endtask

    task automatic test_done_hold();
        for (int i = 0; i < 6; i++) begin
            key = rand128();
            pt  = rand128();
            tick();
            n_tests++;
            if (ct !== C1_CT || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL done_hold cyc %0d: ct=%h valid=%b want %h/1", i, ct, valid, C1_CT);
            end
        end
    endtask

    task automatic test_restart();
        int lat;
        load = 1'b0;
        tick();
        n_tests++;
        if (valid !== 1'b0 || ct !== idle_ct(last_res)) begin
            n_fail++;
            $display("FAIL restart_drop: ct=%h valid=%b want %h/0", ct, valid, idle_ct(last_res));
        end
        start_and_wait(B_KEY, B_PT, lat);
        n_tests++;
        if (lat !== 10 || ct !== B_CT) begin
            n_fail++;
            $display("FAIL restart_b: lat=%0d ct=%h want 10 %h", lat, ct, B_CT);
        end
        n_tests++;
        if (model_enc(B_KEY, B_PT) !== B_CT) begin
            n_fail++;
            $display("FAIL b_model: got %h want %h", model_enc(B_KEY, B_PT), B_CT);
        end
        last_res = B_CT;
        load = 1'b0;
        tick();
    endtask

    task automatic test_abort_load();
        logic [127:0] k, p, exp;
        int lat;
        k = rand128();
        p = rand128();
        exp = model_enc(k, p);
        key  = k;
        pt   = p;
        load = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_tests++;
            if (valid !== 1'b0 || ct !== idle_ct(last_res)) begin
                n_fail++;
                $display("FAIL abort_load cyc %0d: ct=%h valid=%b want %h/0", i, ct, valid,
                         idle_ct(last_res));
            end
        end
        start_and_wait(k, p, lat);
        n_tests++;
        if (lat !== 10 || ct !== exp) begin
            n_fail++;
            $display("FAIL abort_rerun: lat=%0d ct=%h want 10 %h", lat, ct, exp);
        end
        last_res = exp;
        load = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        key  = rand128();
        pt   = rand128();
        load = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ct !== 128'h0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: ct=%h valid=%b want 0/0", ct, valid);
        end
        load = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_tests++;
        if (ct !== 128'h0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: ct=%h valid=%b want 0/0", ct, valid);
        end
        last_res = 128'h0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] k, p, exp;
        int lat;
        for (int n = 0; n < 12; n++) begin
            k = rand128();
            p = rand128();
            exp = model_enc(k, p);
            start_and_wait(k, p, lat);
            n_tests++;
            if (lat !== 10 || ct !== exp) begin
                n_fail++;
                $display("FAIL b2b_%0d: lat=%0d ct=%h want 10 %h", n, lat, ct, exp);
            end
            last_res = exp;
            load = 1'b0;
            key  = rand128();
            pt   = rand128();
            tick();
            n_tests++;
            if (valid !== 1'b0 || ct !== idle_ct(last_res)) begin
                n_fail++;
                $display("FAIL b2b_drop_%0d: ct=%h valid=%b want %h/0", n, ct, valid,
                         idle_ct(last_res));
            end
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        key      = '0;
        pt       = '0;
        last_res = '0;
        build_sbox();
        test_reset();
        test_fips_c1();
        test_done_hold();
        test_restart();
        test_abort_load();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_core.md
# aes_encrypt_core

Iterative AES-128 encryption engine (FIPS-197) computing one round per clock. It is driven by a level-sensitive `load` request from the board-level control logic. The result is presented on `ct` with a `valid` flag for the seven-segment display path. Key and plaintext are captured at start, so later input changes do not disturb a computation in flight.

## Interface
- `NK`, default 4: key length in 32-bit words. Only 4 (AES-128, 10 rounds) is legal; any other value must cause an elaboration error.
- `clk` in, 1: rising-edge clock.
- `rst_n` in, 1: reset. Asynchronous, active-low.
- `key` in, 32*NK: cipher key. Bits [127:120] are key byte 0.
- `load` in, 1: level request. High means encrypt and hold the result; low means idle/abort.
- `pt` in, 128: plaintext. Bits [127:120] are state byte 0 (column-major, FIPS-197 ordering).
- `ct` out, 128: ciphertext, same byte ordering as `pt`.
- `valid` out, 1: `ct` holds the encryption of the captured `pt`/`key`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: when `load`=1 at a rising edge:
  - capture `state <= pt ^ key` and `rkey <= key`;
  - set `round <= 1`;
  - go to RUN.
- RUN, each edge while `load`=1:
  - apply SubBytes, ShiftRows, MixColumns (MixColumns omitted when `round`=10), then AddRoundKey with the next on-the-fly expanded round key;
  - round key update: `rkey` advances by RotWord, SubWord and Rcon, where Rcon = 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10;
  - `round` increments;
  - after round 10: write the final state to `ct`, set `valid`=1, go to DONE.
- DONE: `ct` and `valid`=1 hold while `load`=1. No re-encryption occurs even if `pt` or `key` change.
- `load`=0 in RUN or DONE: next edge goes to IDLE and clears `valid`. In RUN this aborts the operation without updating `ct`.
- Restart requires `load` to fall and rise again; there is no automatic re-trigger.
- S-box: combinational. It may be implemented as a 256-entry function or a GF(2^8) inverse plus affine transform; both must produce identical FIPS-197 values.
- MixColumns uses xtime over polynomial 0x11b.
- Reset (asynchronous):
  - state = IDLE, `round` = 0, internal state and round-key registers = 0;
  - `ct` = 128'h0, `valid` = 0.
- Reset asserted mid-operation aborts immediately; no partial result appears on `ct`.

## Timing
- Latency: `load` sampled high at edge N (capture); rounds at edges N+1..N+10.
- `valid` rises and the new `ct` appears after edge N+10, i.e. 10 cycles after the capture edge.
- `valid` falls one edge after `load` is sampled low.
- `key`/`pt` are sampled only at the capture edge.
- `ct` changes only at the final-round edge, and at reset.
- `ct` and `valid` are registered outputs. There is no combinational path from inputs.

## Configuration
- `AES_CT_CLEAR_EN`:
  - Defined: `ct` is forced to 128'h0 on every edge where `valid` would be 0. The ciphertext is visible only while `valid`=1.
  - Undefined (default): `ct` retains the last completed result through IDLE and RUN, until overwritten or reset.

## Test plan
- Reset, then hold: `rst_n`=0 -> `ct`=0, `valid`=0. `rst_n`=1 with `load`=0 for 20 cycles -> outputs unchanged.
- FIPS-197 C.1 vector:
  - stimulus: `key`=000102030405060708090a0b0c0d0e0f, `pt`=00112233445566778899aabbccddeeff, raise `load`;
  - required: `valid`=1 exactly 10 cycles after the capture edge, `ct`=69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 Appendix B vector:
  - stimulus: `key`=2b7e151628aed2a6abf7158809cf4f3c, `pt`=3243f6a8885a308d313198a2e0370734;
  - required: `ct`=3925841d02dc09fbdc118597196a0b32.
- Input change during DONE: change `pt` and `key` while holding `load`=1 -> `ct` stays at the prior result, `valid` stays 1.
- Drop `load` at DONE, then restart with the B vector:
  - required: `valid`=0 on the next edge;
  - required: `ct` holds 69c4…c55a, or 0 with `AES_CT_CLEAR_EN` defined;
  - required: the new result appears 10 cycles after the restart capture.
- Aborts:
  - drop `load` at round 5 -> `valid` stays 0, `ct` is not updated, the FSM returns to IDLE;
  - assert `rst_n`=0 at round 7 -> `ct`=0 and `valid`=0 immediately.
